// File: rtl/demux1to4_3bit_buf.sv
`default_nettype none
// ============================================================================
// Module      : demux1to4_3bit_buf
// Description : Registered 1-to-4 demultiplexer with valid/ready handshakes.
//               One WIDTH-bit field from a single producer is routed to one of
//               four consumers chosen by in_sel. Each channel owns a one-entry
//               holding slot, so consumers stall independently of each other.
// Optional    : DEMUX_BCAST_EN adds in_bcast, which loads all four slots at
//               once. The transfer is accepted only when every slot can take it.
// Ports       : clk        - clock, all state updates on posedge
//               rst_n      - synchronous reset, active-low
//               in_data    - data to route (WIDTH)
//               in_sel     - destination channel 0..3
//               in_valid   - producer has data
//               in_ready   - block accepts this cycle (combinational)
//               out_data0..3 - per-channel slot data (WIDTH)
//               out_valid  - bit i = slot i holds data
//               out_ready  - bit i = consumer i accepts
//               in_bcast   - broadcast request (DEMUX_BCAST_EN only)
// Revision    : 1.0 - initial release
// ============================================================================
module demux1to4_3bit_buf #(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       in_sel,
  input  logic             in_valid,
  output logic             in_ready,
`ifdef DEMUX_BCAST_EN
  input  logic             in_bcast,
`endif
  output logic [WIDTH-1:0] out_data0,
  output logic [WIDTH-1:0] out_data1,
  output logic [WIDTH-1:0] out_data2,
  output logic [WIDTH-1:0] out_data3,
  output logic [3:0]       out_valid,
  input  logic [3:0]       out_ready
);

  logic [WIDTH-1:0] r_data [4];
  logic [3:0]       r_valid;
  logic [3:0]       w_ch_rdy;
  logic [3:0]       w_load;
  logic             w_accept;
  logic             w_bcast;

`ifdef DEMUX_BCAST_EN
  assign w_bcast = in_bcast;
`else
  assign w_bcast = 1'b0;
`endif

  // A slot can take new data when empty or when it is being drained this cycle.
  assign w_ch_rdy = ~r_valid | out_ready;

  // Deliberately independent of in_valid so the producer can look before it leaps.
  assign in_ready = w_bcast ? (&w_ch_rdy) : w_ch_rdy[in_sel];
  assign w_accept = in_valid & in_ready;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_ch
      assign w_load[gi] = w_accept & (w_bcast | (in_sel == 2'(gi)));

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          r_valid[gi] <= 1'b0;
          r_data[gi]  <= '0;
        end else if (w_load[gi]) begin
          // Refill wins over drain, giving one transfer per cycle per channel.
          r_valid[gi] <= 1'b1;
          r_data[gi]  <= in_data;
        end else if (out_ready[gi]) begin
          // Data is kept on drain; only the flag drops.
          r_valid[gi] <= 1'b0;
        end
      end
    end
  endgenerate

  assign out_data0 = r_data[0];
  assign out_data1 = r_data[1];
  assign out_data2 = r_data[2];
  assign out_data3 = r_data[3];
  assign out_valid = r_valid;

endmodule
`default_nettype wire
